// File: rtl/fp_mult_pkg.sv
// Shared defaults and helpers for the pipelined mini-float multiplier.
// Word layout is {exp[EW-1:0], man[MW-1:0]}. The leading 1 of the mantissa is
// hidden (not stored). The all-zero word is reserved for 0.0.
package fp_mult_pkg;

    localparam int EW_DEF   = 3;
    localparam int MW_DEF   = 4;
    localparam int BIAS_DEF = 2 ** (EW_DEF - 1) - 1;
    localparam int FW       = EW_DEF + MW_DEF;
    localparam int EMAX     = 2 ** EW_DEF - 1;

    // Only the all-zero word means zero. A zero exponent field with a
    // non-zero mantissa is an ordinary small number.
    function automatic logic fp_is_zero(input logic [63:0] w);
        return (w == '0);
    endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Back half of the multiplier datapath. It holds two independent
// combinational paths, one for each of the last two pipeline stages:
//   normalise: mantissa product, select the top MW bits plus the guard bit,
//              and bump the exponent when the product is >= 2.0
//   finish   : round half up on the guard bit, then classify the result as
//              zero / overflow / underflow / normal
module fp_round_norm #(
    parameter int EW  = 3,
    parameter int MW  = 4,
    parameter int RND = 1
) (
    input  logic [MW:0]       ma_i,
    input  logic [MW:0]       mb_i,
    input  logic [EW+1:0]     esum_i,
    output logic [MW-1:0]     man_o,
    output logic              g_o,
    output logic [EW+1:0]     e_o,
    input  logic              zero_i,
    input  logic [MW-1:0]     man_i,
    input  logic              g_i,
    input  logic [EW+1:0]     e_i,
    output logic [EW+MW-1:0]  c_o,
    output logic              ovf_o,
    output logic              unf_o
);

    localparam int PW = 2 * MW + 2;
    localparam logic signed [EW+1:0] EMAX_S = (EW + 2)'(2 ** EW - 1);

    logic [PW-1:0]         p;
    logic [MW:0]           man_sum;
    logic signed [EW+1:0]  e_r;
    logic                  rnd_up;
    logic                  unused_lsbs;

    // Bits below the guard position are dropped. There is no sticky bit.
    assign unused_lsbs = ^p[MW-2:0];

    // Normalise the product. The product of two values in [1,2) lies in
    // [1,4), so at most one right shift is needed.
    always_comb begin
        p = PW'(ma_i) * PW'(mb_i);
        if (p[PW-1]) begin
            man_o = p[2*MW:MW+1];
            g_o   = p[MW];
            e_o   = esum_i + (EW + 2)'(1);
        end else begin
            man_o = p[2*MW-1:MW];
            g_o   = p[MW-1];
            e_o   = esum_i;
        end
    end

    // Round, then classify. A zero operand takes priority over both
    // saturation and flush.
    always_comb begin
        rnd_up  = (RND != 0) && g_i;
        man_sum = {1'b0, man_i} + (MW + 1)'(rnd_up);
        // A carry out of the mantissa leaves the stored bits at zero,
        // which is the correct value for 1.0 * 2^(e+1).
        e_r     = e_i + (EW + 2)'(man_sum[MW]);
        c_o     = '0;
        ovf_o   = 1'b0;
        unf_o   = 1'b0;
        if (!zero_i) begin
            if (e_r > EMAX_S) begin
                c_o   = '1;
                ovf_o = 1'b1;
            end else if (e_r[EW+1] || (e_r == '0 && man_sum[MW-1:0] == '0)) begin
                unf_o = 1'b1;
            end else begin
                c_o = {e_r[EW-1:0], man_sum[MW-1:0]};
            end
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined mini-float multiplier with valid/ready flow control.
// Stage 1 registers the unpacked operands and the biased exponent sum.
// Stage 2 registers the normalised mantissa, guard bit and exponent.
// Stage 3 is the output register: rounded and classified result plus flags.
//
// Handshake: a transfer happens on any rising edge where valid && ready.
// The whole pipeline moves together on 'advance' (= !out_valid || out_ready),
// so a stalled output freezes every stage (global stall). in_ready is
// 'advance'. It does not depend on in_valid.
module fp_mult_pipe
    import fp_mult_pkg::*;
#(
    parameter int EW   = EW_DEF,
    parameter int MW   = MW_DEF,
    parameter int BIAS = 2 ** (EW - 1) - 1,
    parameter int RND  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EW+MW-1:0]  a,
    input  logic [EW+MW-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EW+MW-1:0]  c,
    output logic              ovf,
    output logic              unf
);

    localparam int W = EW + MW;

    logic              advance;

    logic              v1_q, z1_q, z1_d;
    logic [MW:0]       ma1_q, mb1_q, ma1_d, mb1_d;
    logic [EW+1:0]     es1_q, es1_d;

    logic              v2_q, z2_q;
    logic [MW-1:0]     man2_q, man2_d;
    logic              g2_q, g2_d;
    logic [EW+1:0]     e2_q, e2_d;

    logic              ov_q;
    logic [W-1:0]      c_q, c_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;

    assign advance  = !ov_q || out_ready;
    assign in_ready = advance;

    // Unpack. The exponent sum is kept in two's complement with two spare
    // bits, so underflow below zero and overflow up to 2*EMAX+2-BIAS both
    // fit in the field.
    always_comb begin
        z1_d  = fp_is_zero(64'(a)) || fp_is_zero(64'(b));
        ma1_d = {1'b1, a[MW-1:0]};
        mb1_d = {1'b1, b[MW-1:0]};
        es1_d = (EW + 2)'(a[W-1:MW]) + (EW + 2)'(b[W-1:MW]) - (EW + 2)'(BIAS);
    end

    fp_round_norm #(
        .EW  (EW),
        .MW  (MW),
        .RND (RND)
    ) u_round_norm (
        .ma_i   (ma1_q),
        .mb_i   (mb1_q),
        .esum_i (es1_q),
        .man_o  (man2_d),
        .g_o    (g2_d),
        .e_o    (e2_d),
        .zero_i (z2_q),
        .man_i  (man2_q),
        .g_i    (g2_q),
        .e_i    (e2_q),
        .c_o    (c_d),
        .ovf_o  (ovf_d),
        .unf_o  (unf_d)
    );

    // Pipeline registers. The valid chain always shifts on advance. Data
    // registers load only behind a valid, so bubbles leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            z1_q   <= 1'b0;
            ma1_q  <= '0;
            mb1_q  <= '0;
            es1_q  <= '0;
            v2_q   <= 1'b0;
            z2_q   <= 1'b0;
            man2_q <= '0;
            g2_q   <= 1'b0;
            e2_q   <= '0;
            ov_q   <= 1'b0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else if (advance) begin
            v1_q <= in_valid;
            if (in_valid) begin
                z1_q  <= z1_d;
                ma1_q <= ma1_d;
                mb1_q <= mb1_d;
                es1_q <= es1_d;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                z2_q   <= z1_q;
                man2_q <= man2_d;
                g2_q   <= g2_d;
                e2_q   <= e2_d;
            end
            ov_q <= v2_q;
            if (v2_q) begin
                c_q   <= c_d;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end
    end

    assign out_valid = ov_q;
    assign c         = c_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe at EW=3, MW=4, RND=1.
// The driver pushes hand-computed {c, ovf, unf} into exp_q as each operand
// pair is accepted. The monitor pops and compares on every output transfer.
module tb_fp_mult_pipe;

    localparam int FW = 7;
    localparam int NV = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] a, b;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] c;
    logic          ovf, unf;

    int total = 0;
    int bad   = 0;

    logic [FW+1:0] exp_q[$];

    // Directed vectors: operand A, operand B, expected {c, ovf, unf}
    logic [FW-1:0] va [NV] = '{7'b0111010, 7'b1011010, 7'b0110111, 7'b1110000,
                               7'b0000001, 7'b0000000, 7'b0110000, 7'b0010000,
                               7'b0010000, 7'b1000000, 7'b1010000};
    logic [FW-1:0] vb [NV] = '{7'b0111010, 7'b0011101, 7'b0110110, 7'b1110000,
                               7'b0000001, 7'b1110000, 7'b1011010, 7'b0101000,
                               7'b0100000, 7'b1100000, 7'b1100000};
    logic [FW+1:0] ve [NV] = '{{7'b1000101, 2'b00},   // 1.625*1.625 -> 2.625
                               {7'b1001000, 2'b00},   // 6.5*0.453 rounds up to 3.0
                               {7'b1000000, 2'b00},   // round carries out -> 2.0
                               {7'b1111111, 2'b10},   // overflow saturates
                               {7'b0000000, 2'b01},   // exponent < 0 flushes
                               {7'b0000000, 2'b00},   // zero operand, no flags
                               {7'b1011010, 2'b00},   // 1.0*6.5
                               {7'b0001000, 2'b00},   // e==0, man!=0 is normal
                               {7'b0000000, 2'b01},   // e==0, man==0 flushes
                               {7'b1110000, 2'b00},   // e==EMAX, largest exponent
                               {7'b1111111, 2'b10}};  // e==EMAX+1 saturates

    fp_mult_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .ovf       (ovf),
        .unf       (unf)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Call this at a negedge. It returns at the negedge right after the pair
    // was transferred. in_valid stays high for back-to-back issue.
    task automatic send(input logic [FW-1:0] av, input logic [FW-1:0] bv,
                        input logic [FW+1:0] ev);
        int guard = 0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        #1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stuck low, got 0 want 1");
        end
        exp_q.push_back(ev);
        @(negedge clk);
    endtask

    // Monitor / scoreboard
    logic [FW+1:0] held;
    bit            holding = 0;
    always @(negedge clk) begin
        logic [FW+1:0] e;
        #2;
        if (!rst_n) begin
            holding = 0;
        end else begin
            if (holding) begin
                total++;
                if ({c, ovf, unf} !== held || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL hold: got v=%b c=%b ovf=%b unf=%b want v=1 %b", out_valid, c, ovf, unf, held);
                end
            end
            if (out_valid && !out_ready) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_in_ready: got %b want 0", in_ready);
                end
                holding = 1;
                held = {c, ovf, unf};
            end else begin
                holding = 0;
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output: got c=%b ovf=%b unf=%b want none", c, ovf, unf);
                end else begin
                    e = exp_q.pop_front();
                    if ({c, ovf, unf} !== e) begin
                        bad++;
                        $display("FAIL result: got c=%b ovf=%b unf=%b want c=%b ovf=%b unf=%b",
                                 c, ovf, unf, e[FW+1:2], e[1], e[0]);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int guard;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_c", 32'(c), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_unf", 32'(unf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Isolated vectors, with a latency check on the first one
        for (int i = 0; i < NV; i++) begin
            send(va[i], vb[i], ve[i]);
            in_valid = 1'b0;
            if (i == 0) begin
                #1 check("latency_edge1", 32'(out_valid), 32'd0);
                @(negedge clk);
                #1 check("latency_edge2", 32'(out_valid), 32'd0);
                @(negedge clk);
                #1 check("latency_edge3", 32'(out_valid), 32'd1);
                @(negedge clk);
            end else begin
                repeat (3) @(negedge clk);
            end
        end

        // Back-to-back stream with a 5-cycle output stall in the middle
        fork
            begin
                for (int i = 0; i < 8; i++) send(va[i], vb[i], ve[i]);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);

        // Reset with three results in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(va[i], vb[i], ve[i]);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("flight_reset_out_valid", 32'(out_valid), 32'd0);
        check("flight_reset_c", 32'(c), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1 check("no_stale_out", 32'(out_valid), 32'd0);
        end
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
